// File: rtl/ieee_stream_accumulator.sv
// Valid/ready accumulator wrapped around an external combinational IEEE-754 single adder.
// Optional sticky overflow output is built when ACC_OVERFLOW_FLAG_EN is defined.
module ieee_stream_accumulator #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned ADD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_number,
  input  logic              in_sub,
  input  logic              in_last,
  output logic [31:0]       adder_a,
  output logic [31:0]       adder_b,
  output logic              adder_sub,
  input  logic [31:0]       adder_c,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_sum,
`ifdef ACC_OVERFLOW_FLAG_EN
  output logic              out_overflow,
`endif
  output logic [CNT_W-1:0]  out_count
);

  localparam int unsigned WAIT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

  typedef enum logic [1:0] {ACC, ADD, DONE} state_t;

  state_t              state, state_nx;
  logic [31:0]         sum;
  logic [CNT_W-1:0]    count;
  logic                last_q;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                sum_upd;
  logic                in_fire;
  logic                out_fire;
`ifdef ACC_OVERFLOW_FLAG_EN
  logic                ovf;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ACC;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    sum_upd   = 1'b0;
    in_fire   = 1'b0;
    out_fire  = 1'b0;
    case (state)
      ACC: begin
        in_ready = !rst;
        in_fire  = in_valid && !rst;
        if (in_fire) state_nx = ADD;
      end
      ADD: begin
        if (wait_cnt == '0) begin
          sum_upd  = 1'b1;
          state_nx = last_q ? DONE : ACC;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        out_fire  = out_ready;
        if (out_ready) state_nx = ACC;
      end
      default: state_nx = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      count     <= '0;
      adder_a   <= '0;
      adder_b   <= '0;
      adder_sub <= 1'b0;
      last_q    <= 1'b0;
      wait_cnt  <= '0;
`ifdef ACC_OVERFLOW_FLAG_EN
      ovf       <= 1'b0;
`endif
    end else begin
      if (in_fire) begin
        adder_a   <= sum;
        adder_b   <= in_number;
        adder_sub <= in_sub;
        last_q    <= in_last;
        wait_cnt  <= WAIT_W'(ADD_LAT - 1);
      end
      if (state == ADD && wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
      if (sum_upd) begin
        sum <= adder_c;
        if (count != '1) count <= count + 1'b1;
`ifdef ACC_OVERFLOW_FLAG_EN
        if (adder_c[30:23] == 8'hFF) ovf <= 1'b1;
`endif
      end
      if (out_fire) begin
        sum   <= '0;
        count <= '0;
`ifdef ACC_OVERFLOW_FLAG_EN
        ovf   <= 1'b0;
`endif
      end
    end
  end

  assign out_sum   = sum;
  assign out_count = count;
`ifdef ACC_OVERFLOW_FLAG_EN
  assign out_overflow = ovf;
`endif

endmodule

// File: tb/tb_ieee_stream_accumulator.sv
// Randomized self-checking bench: two accumulator instances (default and CNT_W=2/ADD_LAT=3),
// each driven against a real-arithmetic adder model and an integer-sum reference.
module tb_ieee_stream_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid[2], in_ready[2], in_sub[2], in_last[2];
  logic        adder_sub[2], out_valid[2], out_ready[2];
  logic [31:0] in_number[2], adder_a[2], adder_b[2], adder_c[2], out_sum[2];
  logic [7:0]  cnt0;
  logic [1:0]  cnt1;
`ifdef ACC_OVERFLOW_FLAG_EN
  logic        out_overflow[2];
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ieee_stream_accumulator #(.CNT_W(8), .ADD_LAT(1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_number(in_number[0]), .in_sub(in_sub[0]), .in_last(in_last[0]),
    .adder_a(adder_a[0]), .adder_b(adder_b[0]), .adder_sub(adder_sub[0]),
    .adder_c(adder_c[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_sum(out_sum[0]),
`ifdef ACC_OVERFLOW_FLAG_EN
    .out_overflow(out_overflow[0]),
`endif
    .out_count(cnt0));

  ieee_stream_accumulator #(.CNT_W(2), .ADD_LAT(3)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_number(in_number[1]), .in_sub(in_sub[1]), .in_last(in_last[1]),
    .adder_a(adder_a[1]), .adder_b(adder_b[1]), .adder_sub(adder_sub[1]),
    .adder_c(adder_c[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_sum(out_sum[1]),
`ifdef ACC_OVERFLOW_FLAG_EN
    .out_overflow(out_overflow[1]),
`endif
    .out_count(cnt1));

  // Single-float value via real arithmetic (normal/denormal/inf only).
  function automatic real f2r(input logic [31:0] f);
    int  e;
    real r;
    e = int'(f[30:23]);
    if (e == 255) return f[31] ? -1.0e300 : 1.0e300;
    r = (e == 0) ? real'(f[22:0]) : real'({1'b1, f[22:0]});
    if (e == 0) e = 1;
    for (int i = 0; i < e - 150; i++) r = r * 2.0;
    for (int i = 0; i < 150 - e; i++) r = r / 2.0;
    return f[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2f(input real x);
    logic s;
    real  a;
    int   e;
    if (x == 0.0) return 32'h0;
    s = (x < 0.0);
    a = s ? -x : x;
    if (a >= 3.4028236692093846e38) return {s, 8'hFF, 23'h0};
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    return {s, 8'(e + 127), 23'($rtoi((a - 1.0) * 8388608.0))};
  endfunction

  // Exact encoding of a small integer as a single-precision float.
  function automatic logic [31:0] i2f(input int v);
    logic        s;
    logic [31:0] m;
    int          p;
    if (v == 0) return 32'h0;
    s = (v < 0);
    m = s ? 32'(-v) : 32'(v);
    p = 0;
    for (int i = 0; i < 24; i++) if (m[i]) p = i;
    return {s, 8'(127 + p), 23'(m << (23 - p))};
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int cmax(input int k);
    return (k == 0) ? 255 : 3;
  endfunction

  function automatic logic [31:0] cnt_of(input int k);
    return (k == 0) ? {24'h0, cnt0} : {30'h0, cnt1};
  endfunction

  function automatic logic [31:0] ovf_of(input int k);
`ifdef ACC_OVERFLOW_FLAG_EN
    return {31'h0, out_overflow[k]};
`else
    return (k < 0) ? 32'h1 : 32'h0;
`endif
  endfunction

  always_comb begin
    for (int k = 0; k < 2; k++)
      adder_c[k] = r2f(adder_sub[k] ? f2r(adder_a[k]) - f2r(adder_b[k])
                                    : f2r(adder_a[k]) + f2r(adder_b[k]));
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input int k, input logic [31:0] num, input logic sub, input logic last,
                      input logic [31:0] exp_a, input logic meas);
    int n;
    @(negedge clk);
    in_valid[k] = 1'b1; in_number[k] = num; in_sub[k] = sub; in_last[k] = last;
    n = 0;
    while (!in_ready[k] && n < 50) begin @(negedge clk); n++; end
    if (!in_ready[k]) begin
      check_eq("in_ready_timeout", {31'h0, in_ready[k]}, 32'h1);
      in_valid[k] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid[k] = 1'b0; in_last[k] = 1'b0;
    if (!last && meas) begin
      n = 0;
      while (n < 20) begin
        @(negedge clk);
        if (in_ready[k]) break;
        n++;
        check_eq("adder_a_hold", adder_a[k], exp_a);
        check_eq("adder_b_hold", adder_b[k], num);
        check_eq("adder_sub_hold", {31'h0, adder_sub[k]}, {31'h0, sub});
      end
      check_eq("ready_period", 32'(n + 1), 32'(lat(k) + 1));
    end
  endtask

  task automatic collect(input int k, input logic [31:0] exp_sum, input int exp_cnt,
                         input logic exp_ovf, input int stall);
    int n;
    n = 0;
    while (!out_valid[k] && n < 50) begin @(negedge clk); n++; end
    check_eq("out_valid", {31'h0, out_valid[k]}, 32'h1);
    if (!out_valid[k]) return;
    check_eq("out_sum", out_sum[k], exp_sum);
    check_eq("out_count", cnt_of(k), 32'(exp_cnt));
`ifdef ACC_OVERFLOW_FLAG_EN
    check_eq("out_overflow", ovf_of(k), {31'h0, exp_ovf});
`endif
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_eq("stall_valid", {31'h0, out_valid[k]}, 32'h1);
      check_eq("stall_sum", out_sum[k], exp_sum);
      check_eq("stall_count", cnt_of(k), 32'(exp_cnt));
      check_eq("stall_in_ready", {31'h0, in_ready[k]}, 32'h0);
    end
    @(negedge clk);
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
    @(negedge clk);
    check_eq("post_valid", {31'h0, out_valid[k]}, 32'h0);
    check_eq("post_sum", out_sum[k], 32'h0);
    check_eq("post_count", cnt_of(k), 32'h0);
    check_eq("post_ovf", ovf_of(k), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int len, v, acc;
    logic sub;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0; in_sub[k] = 1'b0; in_last[k] = 1'b0;
      in_number[k] = 32'h0; out_ready[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check_eq("rst_out_valid", {31'h0, out_valid[k]}, 32'h0);
      check_eq("rst_out_sum", out_sum[k], 32'h0);
      check_eq("rst_out_count", cnt_of(k), 32'h0);
      check_eq("rst_adder_a", adder_a[k], 32'h0);
      check_eq("rst_adder_b", adder_b[k], 32'h0);
      check_eq("rst_adder_sub", {31'h0, adder_sub[k]}, 32'h0);
    end
    rst = 1'b0;
    @(negedge clk);
    check_eq("rel_in_ready0", {31'h0, in_ready[0]}, 32'h1);
    check_eq("rel_in_ready1", {31'h0, in_ready[1]}, 32'h1);

    // Directed cases on the default instance.
    send(0, 32'h3F800000, 1'b0, 1'b0, 32'h0, 1'b1);
    send(0, 32'h40000000, 1'b0, 1'b1, 32'h3F800000, 1'b1);
    collect(0, 32'h40400000, 2, 1'b0, 5);
    send(0, 32'h3F800000, 1'b1, 1'b1, 32'h0, 1'b1);
    collect(0, 32'hBF800000, 1, 1'b0, 0);
    send(0, 32'h7F7FFFFF, 1'b0, 1'b0, 32'h0, 1'b1);
    send(0, 32'h7F7FFFFF, 1'b0, 1'b1, 32'h7F7FFFFF, 1'b1);
    collect(0, 32'h7F800000, 2, 1'b1, 1);

    // Reset while the second operand is in the adder.
    send(0, 32'h3F800000, 1'b0, 1'b0, 32'h0, 1'b1);
    send(0, 32'h40000000, 1'b0, 1'b0, 32'h3F800000, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort_sum", out_sum[0], 32'h0);
    check_eq("abort_count", cnt_of(0), 32'h0);
    check_eq("abort_in_ready", {31'h0, in_ready[0]}, 32'h1);
    check_eq("abort_valid", {31'h0, out_valid[0]}, 32'h0);
    send(0, 32'h40400000, 1'b0, 1'b1, 32'h0, 1'b1);
    collect(0, 32'h40400000, 1, 1'b0, 0);

    // Saturating count on the narrow, slow instance.
    for (int j = 0; j < 5; j++)
      send(1, 32'h3F800000, 1'b0, (j == 4), i2f(j), 1'b1);
    collect(1, 32'h40A00000, 3, 1'b0, 0);

    // Random integer-valued streams, reference kept as an exact integer sum.
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 6; s++) begin
        len = int'($urandom_range(1, 6));
        acc = 0;
        for (int j = 0; j < len; j++) begin
          v   = int'($urandom_range(0, 100)) - 50;
          sub = 1'($urandom_range(0, 1));
          send(k, i2f(v), sub, (j == len - 1), i2f(acc), 1'b1);
          acc = sub ? acc - v : acc + v;
        end
        collect(k, i2f(acc), (len < cmax(k)) ? len : cmax(k), 1'b0, int'($urandom_range(0, 3)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
